// File: rtl/pulpino_gpio_word_link.sv
// Word-to-byte bridge between the host register path and the PULPino GPIO port.
// Host words are queued in a TX FIFO and sent as four little-endian bytes under a
// 2-bit turn/ack token handshake. Returned bytes are assembled into words and
// queued in an RX FIFO for the host.
module pulpino_gpio_word_link #(
    parameter int unsigned pDEPTH_LOG2 = 2
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    input  logic                   i_clear,
    input  logic [31:0]            i_host_wr_data,
    input  logic                   i_host_wr_valid,
    output logic                   o_host_wr_ready,
    output logic [31:0]            o_host_rd_data,
    output logic                   o_host_rd_valid,
    input  logic                   i_host_rd_pop,
    output logic [7:0]             o_gpio_in_byte,
    output logic [1:0]             o_gpio_in_turn,
    input  logic [1:0]             i_pulpino_in_ack,
    input  logic [7:0]             i_gpio_out_byte,
    input  logic [1:0]             i_pulpino_out_turn,
    output logic [1:0]             o_gpio_out_ack,
    output logic [pDEPTH_LOG2:0]   o_tx_level,
    output logic [pDEPTH_LOG2:0]   o_rx_level,
    output logic                   o_tx_drop,
    output logic                   o_proto_err
);

    localparam int unsigned Depth = 1 << pDEPTH_LOG2;
    localparam int unsigned LW    = pDEPTH_LOG2 + 1;

    typedef enum logic [0:0] {
        StIdle,
        StWaitAck
    } tx_state_e;

    // ------------------------------------------------------------------
    // TX word FIFO
    // ------------------------------------------------------------------
    logic [31:0]            r_tx_mem [Depth];
    logic [pDEPTH_LOG2-1:0] r_tx_wptr;
    logic [pDEPTH_LOG2-1:0] r_tx_rptr;
    logic [LW-1:0]          r_tx_level;
    logic                   w_tx_full;
    logic                   w_tx_empty;
    logic                   w_tx_push;
    logic                   w_tx_pop;
    logic [31:0]            w_tx_head;

    assign w_tx_full  = (r_tx_level == LW'(Depth));
    assign w_tx_empty = (r_tx_level == '0);
    assign w_tx_push  = i_host_wr_valid & ~w_tx_full & ~i_clear;
    assign w_tx_head  = r_tx_mem[r_tx_rptr];

    // TX FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge i_clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= i_host_wr_data;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
        end else if (i_clear) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            r_tx_level <= r_tx_level + LW'(w_tx_push) - LW'(w_tx_pop);
        end
    end

    // ------------------------------------------------------------------
    // TX engine
    // ------------------------------------------------------------------
    tx_state_e   r_tx_state;
    tx_state_e   w_tx_state_next;
    logic [31:0] r_tx_shift;
    logic [7:0]  r_in_byte;
    logic [1:0]  r_in_turn;
    logic [1:0]  r_tx_idx;
    logic        w_tx_ack_match;
    logic        w_tx_load;
    logic        w_tx_adv;

    assign w_tx_ack_match = (i_pulpino_in_ack == r_in_turn);

    // TX state register
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_tx_state <= StIdle;
        end else begin
            r_tx_state <= w_tx_state_next;
        end
    end

    // TX next-state: clear forces IDLE from anywhere
    always_comb begin
        w_tx_state_next = r_tx_state;
        if (i_clear) begin
            w_tx_state_next = StIdle;
        end else begin
            unique case (r_tx_state)
                StIdle: begin
                    if (!w_tx_empty) begin
                        w_tx_state_next = StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (w_tx_ack_match && (r_tx_idx == 2'd3)) begin
                        w_tx_state_next = StIdle;
                    end
                end
                default: w_tx_state_next = StIdle;
            endcase
        end
    end

    // TX control outputs: load a fresh word or step to the next byte
    always_comb begin
        w_tx_pop  = 1'b0;
        w_tx_load = 1'b0;
        w_tx_adv  = 1'b0;
        if (!i_clear) begin
            unique case (r_tx_state)
                StIdle: begin
                    if (!w_tx_empty) begin
                        w_tx_pop  = 1'b1;
                        w_tx_load = 1'b1;
                    end
                end
                StWaitAck: begin
                    if (w_tx_ack_match && (r_tx_idx != 2'd3)) begin
                        w_tx_adv = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // TX byte lane; byte and turn always change together
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_tx_shift <= '0;
            r_in_byte  <= '0;
            r_in_turn  <= '0;
            r_tx_idx   <= '0;
        end else if (w_tx_load) begin
            r_tx_shift <= w_tx_head;
            r_in_byte  <= w_tx_head[7:0];
            r_in_turn  <= r_in_turn + 1'b1;
            r_tx_idx   <= '0;
        end else if (w_tx_adv) begin
            r_tx_shift <= {8'h00, r_tx_shift[31:8]};
            r_in_byte  <= r_tx_shift[15:8];
            r_in_turn  <= r_in_turn + 1'b1;
            r_tx_idx   <= r_tx_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX word FIFO
    // ------------------------------------------------------------------
    logic [31:0]            r_rx_mem [Depth];
    logic [pDEPTH_LOG2-1:0] r_rx_wptr;
    logic [pDEPTH_LOG2-1:0] r_rx_rptr;
    logic [LW-1:0]          r_rx_level;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic                   w_rx_push;
    logic                   w_rx_pop;
    logic [31:0]            w_rx_word;

    assign w_rx_full  = (r_rx_level == LW'(Depth));
    assign w_rx_empty = (r_rx_level == '0);
    assign w_rx_pop   = i_host_rd_pop & ~w_rx_empty & ~i_clear;

    // RX FIFO storage
    always_ff @(posedge i_clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= w_rx_word;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
        end else if (i_clear) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            r_rx_level <= r_rx_level + LW'(w_rx_push) - LW'(w_rx_pop);
        end
    end

    // ------------------------------------------------------------------
    // RX engine
    // ------------------------------------------------------------------
    logic [1:0]  r_out_ack;
    logic [1:0]  r_rx_idx;
    logic [23:0] r_rx_asm;
    logic [1:0]  w_rx_diff;
    logic        w_rx_pending;
    logic        w_rx_last;
    logic        w_rx_accept;

    assign w_rx_diff    = i_pulpino_out_turn - r_out_ack;
    assign w_rx_pending = (w_rx_diff != 2'd0);
    assign w_rx_last    = (r_rx_idx == 2'd3);
    // Last byte waits for FIFO space; a same-cycle host pop frees a slot
    assign w_rx_accept  = w_rx_pending & ~i_clear & (~w_rx_last | ~w_rx_full | w_rx_pop);
    assign w_rx_push    = w_rx_accept & w_rx_last;
    assign w_rx_word    = {i_gpio_out_byte, r_rx_asm};

    // RX byte acceptance and word assembly
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_out_ack <= '0;
            r_rx_idx  <= '0;
            r_rx_asm  <= '0;
        end else if (i_clear) begin
            // Discard anything pending by catching the ack up to the turn
            r_out_ack <= i_pulpino_out_turn;
            r_rx_idx  <= '0;
        end else if (w_rx_accept) begin
            r_out_ack <= r_out_ack + 1'b1;
            r_rx_idx  <= r_rx_idx + 1'b1;
            case (r_rx_idx)
                2'd0:    r_rx_asm[7:0]   <= i_gpio_out_byte;
                2'd1:    r_rx_asm[15:8]  <= i_gpio_out_byte;
                2'd2:    r_rx_asm[23:16] <= i_gpio_out_byte;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags
    // ------------------------------------------------------------------
    logic r_tx_drop;
    logic r_proto_err;

    // Flags accumulate until reset; clear leaves them alone
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_tx_drop   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_tx_drop   <= r_tx_drop | (i_host_wr_valid & w_tx_full);
            r_proto_err <= r_proto_err | w_rx_diff[1];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_host_wr_ready = ~w_tx_full;
    assign o_host_rd_valid = ~w_rx_empty;
    assign o_host_rd_data  = w_rx_empty ? 32'h0 : r_rx_mem[r_rx_rptr];
    assign o_gpio_in_byte  = r_in_byte;
    assign o_gpio_in_turn  = r_in_turn;
    assign o_gpio_out_ack  = r_out_ack;
    assign o_tx_level      = r_tx_level;
    assign o_rx_level      = r_rx_level;
    assign o_tx_drop       = r_tx_drop;
    assign o_proto_err     = r_proto_err;

endmodule

// File: tb/tb_pulpino_gpio_word_link.sv
// Bench for pulpino_gpio_word_link: scenario tasks with queue-based scoreboards
// for TX bytes and RX words.
module tb_pulpino_gpio_word_link;

    logic        clk;
    logic        resetn;
    logic        clear;
    logic [31:0] host_wr_data;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [31:0] host_rd_data;
    logic        host_rd_valid;
    logic        host_rd_pop;
    logic [7:0]  gpio_in_byte;
    logic [1:0]  gpio_in_turn;
    logic [1:0]  pulpino_in_ack;
    logic [7:0]  gpio_out_byte;
    logic [1:0]  pulpino_out_turn;
    logic [1:0]  gpio_out_ack;
    logic [2:0]  tx_level;
    logic [2:0]  rx_level;
    logic        tx_drop;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_bytes [$];
    logic [1:0]  exp_turns [$];
    logic [31:0] exp_words [$];

    pulpino_gpio_word_link #(.pDEPTH_LOG2(2)) dut (
        .i_clk              (clk),
        .i_resetn           (resetn),
        .i_clear            (clear),
        .i_host_wr_data     (host_wr_data),
        .i_host_wr_valid    (host_wr_valid),
        .o_host_wr_ready    (host_wr_ready),
        .o_host_rd_data     (host_rd_data),
        .o_host_rd_valid    (host_rd_valid),
        .i_host_rd_pop      (host_rd_pop),
        .o_gpio_in_byte     (gpio_in_byte),
        .o_gpio_in_turn     (gpio_in_turn),
        .i_pulpino_in_ack   (pulpino_in_ack),
        .i_gpio_out_byte    (gpio_out_byte),
        .i_pulpino_out_turn (pulpino_out_turn),
        .o_gpio_out_ack     (gpio_out_ack),
        .o_tx_level         (tx_level),
        .o_rx_level         (rx_level),
        .o_tx_drop          (tx_drop),
        .o_proto_err        (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        host_wr_data  = w;
        host_wr_valid = 1'b1;
        tick();
        host_wr_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        gpio_out_byte    = b;
        pulpino_out_turn = pulpino_out_turn + 2'd1;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_words.push_back(w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Compare the RX head against the scoreboard, then pop it
    task automatic pop_and_check(input string name);
        logic [31:0] e;
        checks++;
        if (exp_words.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, rd_valid=%0b", name, host_rd_valid);
        end else begin
            e = exp_words.pop_front();
            if (host_rd_valid !== 1'b1 || host_rd_data !== e) begin
                errors++;
                $display("FAIL %s: got valid=%0b data=%h, want valid=1 data=%h",
                         name, host_rd_valid, host_rd_data, e);
            end
        end
        host_rd_pop = 1'b1;
        tick();
        host_rd_pop = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({gpio_in_byte, gpio_in_turn, gpio_out_ack, tx_level, rx_level, tx_drop, proto_err,
             host_rd_valid, host_rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: byte=%h turn=%0d ack=%0d txl=%0d rxl=%0d drop=%0b err=%0b rv=%0b rd=%h, want all 0",
                     gpio_in_byte, gpio_in_turn, gpio_out_ack, tx_level, rx_level, tx_drop,
                     proto_err, host_rd_valid, host_rd_data);
        end
        checks++;
        if (host_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b want 1", host_wr_ready);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_tx_word();
        logic [1:0] prev;
        logic       seen;
        for (int i = 0; i < 4; i++) begin
            exp_bytes.push_back(8'h11 * 8'(i + 1));
            exp_turns.push_back(2'(i + 1));
        end
        push_word(32'h44332211);
        checks++;
        if (tx_level !== 3'd1 || gpio_in_turn !== 2'd0) begin
            errors++;
            $display("FAIL tx_push_latency: got level=%0d turn=%0d want level=1 turn=0",
                     tx_level, gpio_in_turn);
        end
        for (int i = 0; i < 4; i++) begin
            prev = gpio_in_turn;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (gpio_in_turn !== prev) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL tx_byte%0d_timeout: turn stuck at %0d", i, gpio_in_turn);
            end else begin
                logic [7:0] eb;
                logic [1:0] et;
                eb = exp_bytes.pop_front();
                et = exp_turns.pop_front();
                if (gpio_in_byte !== eb || gpio_in_turn !== et) begin
                    errors++;
                    $display("FAIL tx_byte%0d: got byte=%h turn=%0d want byte=%h turn=%0d",
                             i, gpio_in_byte, gpio_in_turn, eb, et);
                end
            end
            repeat (3) tick();
            pulpino_in_ack = gpio_in_turn;
        end
        repeat (4) tick();
        checks++;
        if (tx_level !== 3'd0 || gpio_in_byte !== 8'h44 || gpio_in_turn !== 2'd0) begin
            errors++;
            $display("FAIL tx_word_done: got level=%0d byte=%h turn=%0d want 0/44/0",
                     tx_level, gpio_in_byte, gpio_in_turn);
        end
    endtask

    task automatic test_tx_backpressure();
        // ack stays at 0 so the engine stalls on the first byte
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (host_wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL tx_bp_ready%0d: got %0b want 1", i, host_wr_ready);
            end
            push_word(32'hC0DE0000 + 32'(i));
        end
        checks++;
        if (tx_level !== 3'd4 || host_wr_ready !== 1'b0 || tx_drop !== 1'b0) begin
            errors++;
            $display("FAIL tx_bp_full: got level=%0d ready=%0b drop=%0b want 4/0/0",
                     tx_level, host_wr_ready, tx_drop);
        end
        push_word(32'hBAD0BAD0);
        checks++;
        if (tx_level !== 3'd4 || host_wr_ready !== 1'b0 || tx_drop !== 1'b1) begin
            errors++;
            $display("FAIL tx_bp_drop: got level=%0d ready=%0b drop=%0b want 4/0/1",
                     tx_level, host_wr_ready, tx_drop);
        end
        checks++;
        if (gpio_in_byte !== 8'h00 || gpio_in_turn !== 2'd1) begin
            errors++;
            $display("FAIL tx_bp_hold: got byte=%h turn=%0d want 00/1", gpio_in_byte, gpio_in_turn);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        pulpino_in_ack = 2'd1;
        tick();
        checks++;
        if (tx_level !== 3'd0 || tx_drop !== 1'b1 || gpio_in_turn !== 2'd1) begin
            errors++;
            $display("FAIL tx_bp_clear: got level=%0d drop=%0b turn=%0d want 0/1/1",
                     tx_level, tx_drop, gpio_in_turn);
        end
    endtask

    task automatic test_rx_word();
        send_word(32'hDEADBEEF);
        checks++;
        if (host_rd_valid !== 1'b1 || gpio_out_ack !== 2'd0 || rx_level !== 3'd1) begin
            errors++;
            $display("FAIL rx_word: got valid=%0b ack=%0d level=%0d want 1/0/1",
                     host_rd_valid, gpio_out_ack, rx_level);
        end
        pop_and_check("rx_word_data");
        checks++;
        if (rx_level !== 3'd0 || host_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_word_pop: got level=%0d valid=%0b want 0/0", rx_level, host_rd_valid);
        end
    endtask

    task automatic test_rx_full();
        logic [1:0] turn_before;
        for (int i = 0; i < 4; i++) send_word(32'h10203040 + 32'(i * 32'h01010101));
        checks++;
        if (rx_level !== 3'd4) begin
            errors++;
            $display("FAIL rx_full_level: got %0d want 4", rx_level);
        end
        send_word(32'hA5A55A5A);
        repeat (2) tick();
        turn_before = pulpino_out_turn - 2'd1;
        checks++;
        if (gpio_out_ack !== turn_before || rx_level !== 3'd4) begin
            errors++;
            $display("FAIL rx_full_stall: got ack=%0d level=%0d want ack=%0d level=4",
                     gpio_out_ack, rx_level, turn_before);
        end
        pop_and_check("rx_full_head");
        checks++;
        if (gpio_out_ack !== pulpino_out_turn || rx_level !== 3'd4) begin
            errors++;
            $display("FAIL rx_full_release: got ack=%0d level=%0d want ack=%0d level=4",
                     gpio_out_ack, rx_level, pulpino_out_turn);
        end
        for (int i = 0; i < 4; i++) pop_and_check("rx_full_drain");
        checks++;
        if (rx_level !== 3'd0) begin
            errors++;
            $display("FAIL rx_full_empty: got %0d want 0", rx_level);
        end
    endtask

    task automatic test_proto_err();
        logic [1:0] base;
        base = pulpino_out_turn;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_pre: got %0b want 0", proto_err);
        end
        gpio_out_byte    = 8'h5A;
        pulpino_out_turn = base + 2'd2;
        tick();
        checks++;
        if (proto_err !== 1'b1 || gpio_out_ack !== base + 2'd1) begin
            errors++;
            $display("FAIL proto_jump: got err=%0b ack=%0d want 1/%0d", proto_err, gpio_out_ack,
                     2'(base + 2'd1));
        end
        tick();
        checks++;
        if (gpio_out_ack !== base + 2'd2) begin
            errors++;
            $display("FAIL proto_catchup: got ack=%0d want %0d", gpio_out_ack, 2'(base + 2'd2));
        end
        exp_words.push_back(32'h22115A5A);
        send_byte(8'h11);
        send_byte(8'h22);
        pop_and_check("proto_word");
    endtask

    task automatic test_clear();
        push_word(32'hA1B2C3D4);
        tick();
        checks++;
        if (gpio_in_byte !== 8'hD4 || gpio_in_turn !== 2'd2) begin
            errors++;
            $display("FAIL clr_tx_b0: got byte=%h turn=%0d want D4/2", gpio_in_byte, gpio_in_turn);
        end
        pulpino_in_ack = 2'd2;
        tick();
        checks++;
        if (gpio_in_byte !== 8'hC3 || gpio_in_turn !== 2'd3) begin
            errors++;
            $display("FAIL clr_tx_b1: got byte=%h turn=%0d want C3/3", gpio_in_byte, gpio_in_turn);
        end
        push_word(32'h55667788);
        send_byte(8'hAA);
        send_byte(8'hBB);
        // A pending RX byte during clear must be discarded
        gpio_out_byte    = 8'hCC;
        pulpino_out_turn = pulpino_out_turn + 2'd1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (tx_level !== 3'd0 || rx_level !== 3'd0 || gpio_out_ack !== pulpino_out_turn ||
            gpio_in_turn !== 2'd3 || gpio_in_byte !== 8'hC3) begin
            errors++;
            $display("FAIL clr_state: got txl=%0d rxl=%0d ack=%0d turn=%0d byte=%h want 0/0/%0d/3/C3",
                     tx_level, rx_level, gpio_out_ack, gpio_in_turn, gpio_in_byte, pulpino_out_turn);
        end
        // A matching ack must not advance anything if TX really went idle
        pulpino_in_ack = 2'd3;
        repeat (3) tick();
        checks++;
        if (gpio_in_turn !== 2'd3 || gpio_in_byte !== 8'hC3) begin
            errors++;
            $display("FAIL clr_tx_idle: got turn=%0d byte=%h want 3/C3", gpio_in_turn, gpio_in_byte);
        end
        send_word(32'h04030201);
        pop_and_check("clr_rx_realign");
    endtask

    task automatic test_reset_mid();
        push_word(32'h0F0E0D0C);
        repeat (2) tick();
        send_byte(8'h77);
        send_byte(8'h88);
        resetn           = 1'b0;
        pulpino_in_ack   = 2'd0;
        pulpino_out_turn = 2'd0;
        tick();
        checks++;
        if ({gpio_in_byte, gpio_in_turn, gpio_out_ack, tx_level, rx_level, tx_drop, proto_err,
             host_rd_valid, host_rd_data} !== '0 || host_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: byte=%h turn=%0d ack=%0d txl=%0d rxl=%0d drop=%0b err=%0b rv=%0b rdy=%0b, want zeros and ready=1",
                     gpio_in_byte, gpio_in_turn, gpio_out_ack, tx_level, rx_level, tx_drop,
                     proto_err, host_rd_valid, host_wr_ready);
        end
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        resetn           = 1'b0;
        clear            = 1'b0;
        host_wr_data     = '0;
        host_wr_valid    = 1'b0;
        host_rd_pop      = 1'b0;
        pulpino_in_ack   = 2'd0;
        gpio_out_byte    = '0;
        pulpino_out_turn = 2'd0;
        test_reset();
        test_tx_word();
        test_tx_backpressure();
        test_rx_word();
        test_rx_full();
        test_proto_err();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulpino_gpio_word_link.md
# pulpino_gpio_word_link

Word-to-byte bridge between the host register path and the PULPino GPIO port, in the `pulpino_clk` domain. Host 32-bit words pass through a TX word FIFO and are serialized little-endian onto an 8-bit GPIO byte lane with a 2-bit turn/ack token handshake. Bytes returned by PULPino software are assembled into 32-bit words and queued in an RX word FIFO for the host. Host-side signals arrive already synchronized into `clk`; no CDC logic lives in this block.

## Interface
- pDEPTH_LOG2, 2, log2 of each word FIFO depth (4 words TX, 4 words RX)
- clk  in  1  pulpino_clk; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- clear  in  1  synchronous flush of both FIFOs and both engines (level, one cycle suffices)
- host_wr_data  in  32  word to send to PULPino
- host_wr_valid  in  1  push request
- host_wr_ready  out  1  TX FIFO not full
- host_rd_data  out  32  head of RX FIFO (first-word fall-through)
- host_rd_valid  out  1  RX FIFO not empty
- host_rd_pop  in  1  consume head; ignored when empty
- gpio_in_byte  out  8  byte presented to PULPino
- gpio_in_turn  out  2  TX token; increments once per presented byte
- pulpino_in_ack  in  2  PULPino copies gpio_in_turn here after reading byte
- gpio_out_byte  in  8  byte from PULPino
- pulpino_out_turn  in  2  PULPino increments once per new byte
- gpio_out_ack  out  2  RX token; increments once per accepted byte
- tx_level  out  pDEPTH_LOG2+1  TX FIFO occupancy
- rx_level  out  pDEPTH_LOG2+1  RX FIFO occupancy
- tx_drop  out  1  sticky: host_wr_valid while !host_wr_ready
- proto_err  out  1  sticky: pulpino_out_turn - gpio_out_ack (mod 4) ∉ {0,1}

## Operation
- Reset (resetn=0 at edge): all outputs 0, FIFOs empty, TX state IDLE, RX index 0; host_wr_ready=1 after first edge with resetn=1 (combinational from level, so 1 already during reset once level=0).
- TX FIFO: push on host_wr_valid&host_wr_ready; full-write dropped, sets tx_drop. Push and pop same cycle when non-empty and non-full: level unchanged.
- TX engine states:
  - IDLE: if TX FIFO non-empty: pop; shift <= word; gpio_in_byte <= word[7:0]; gpio_in_turn <= turn+1; idx <= 0; -> WAIT_ACK.
  - WAIT_ACK: when pulpino_in_ack == gpio_in_turn: if idx<3, gpio_in_byte <= next byte (bits [15:8], [23:16], [31:24] in order), turn+1, idx+1, stay; if idx==3 -> IDLE. Otherwise hold byte and turn stable.
- Byte order little-endian both directions; byte 0 = bits [7:0].
- RX engine: byte pending when pulpino_out_turn != gpio_out_ack. Bytes 0–2: capture gpio_out_byte into assembly[idx], gpio_out_ack+1, idx+1. Byte 3: accepted only if RX FIFO not full (or popped in same cycle); push {byte, assembly[23:0]}, ack+1, idx <= 0. RX full: ack withheld (backpressure), no data loss.
- proto_err: set when mod-4 difference is 2 or 3; engine still advances by exactly one byte per cycle.
- clear: both FIFOs emptied, TX -> IDLE, RX idx <= 0, gpio_out_ack <= pulpino_out_turn (pending byte discarded); gpio_in_turn, gpio_in_byte, sticky flags retained. clear beats push/pop/accept in same cycle.
- Sticky flags cleared only by resetn.

## Timing
- host push at edge N -> gpio_in_byte/gpio_in_turn update at edge N+1 (TX in IDLE).
- ack matching at edge M -> next byte and turn at edge M (registered, visible M+1 cycle); word finish -> IDLE at M, next word's byte 0 at M+1 earliest: 1 idle cycle between words.
- gpio_in_byte and gpio_in_turn change on the same edge; byte stable while turn unchanged.
- RX: at most one byte per cycle; 4th byte accept edge K -> host_rd_valid=1 after K.
- host_rd_data valid same cycle as host_rd_valid; pop at edge P shows next head after P.

## Test plan
- Reset then push 0x44332211, PULPino model acks each turn after 3 cycles -> gpio_in_byte sequence 0x11,0x22,0x33,0x44, gpio_in_turn 1,2,3,0, tx_level back to 0.
- Push 5 words with PULPino never acking -> first 4 accepted (one popped into engine, so 5th also accepted), 6th push rejected: host_wr_ready=0, tx_drop=1, tx_level=4.
- PULPino sends bytes 0xEF,0xBE,0xAD,0xDE incrementing turn each -> host_rd_data=0xDEADBEEF, host_rd_valid=1, gpio_out_ack=0 (wrapped after 4).
- Fill RX FIFO with 4 words without popping, send 5th word -> gpio_out_ack stalls at byte 3 of word 5; one host_rd_pop -> byte accepted next edge, rx_level stays 4.
- Jump pulpino_out_turn by 2 -> proto_err=1, one byte accepted per cycle until ack catches up.
- Mid-word clear with 2 bytes of TX sent and 2 RX bytes assembled -> tx_level=rx_level=0, TX IDLE, gpio_out_ack=pulpino_out_turn, gpio_in_turn unchanged; resetn=0 mid-transfer -> all outputs 0 after the edge.
